// File: rtl/n64adv2_ctrl_sniffer_if.sv
// CPU-facing side of the controller sniffer: IGR enable, data word and the
// toggle-acknowledge handshake. The sniffer takes the slave modport.
interface n64adv2_ctrl_sniffer_if;
    logic        use_igr_i;
    logic        ctrl_data_tack_i;
    logic [31:0] ctrl_data_o;
    logic        new_ctrl_data_o;
    logic        ctrl_detected_o;

    modport master (
        output use_igr_i,
        output ctrl_data_tack_i,
        input  ctrl_data_o,
        input  new_ctrl_data_o,
        input  ctrl_detected_o
    );

    modport slave (
        input  use_igr_i,
        input  ctrl_data_tack_i,
        output ctrl_data_o,
        output new_ctrl_data_o,
        output ctrl_detected_o
    );
endinterface

// File: rtl/n64adv2_ctrl_sniffer.sv
// Passive N64 controller-bus sniffer. Decodes the console poll command and
// the 32-bit controller answer, hands the word to the CPU domain with a
// toggle-acknowledge handshake and drives an in-game-reset pulse on the
// open-drain console reset line when the configured button combo is held.
module n64adv2_ctrl_sniffer #(
    parameter logic [15:0] IGR_COMBO = 16'h0C0C,
    parameter int unsigned RST_CNT_W = 20
) (
    input  logic                  CTRL_CLK,
    input  logic                  CTRL_nRST,
    input  logic                  CTRL_i,
    n64adv2_ctrl_sniffer_if.slave bus,
    inout  wire                   N64_nRST_io
);

    typedef enum logic [1:0] {StWait, StN64Rd, StCtrlRd} state_e;

    // Bits land LSB-first, so the poll command 0x01 (sent MSB first) reads
    // back bit-reversed.
    localparam logic [7:0] PollCmdRev = 8'h80;

    logic [1:0]           use_igr_sync_q;
    logic [1:0]           tack_sync_q;
    logic                 tack_prev_q;
    logic [2:0]           hist_q, hist_d;
    logic [7:0]           wait_cnt_q, wait_cnt_d;
    logic [7:0]           low_cnt_q, low_cnt_d;
    state_e               state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [31:0]          shreg_q, shreg_d;
    logic [31:0]          frame_q, frame_d;
    logic                 pend_q, pend_d;
    logic                 det_q, det_d;
    logic [31:0]          data_q, data_d;
    logic                 new_q, new_d;
    logic                 armed_q, armed_d;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;

    logic neg_edge, pos_edge, any_edge, wait_sat, bit_val;
    logic frame_latch, ack_chg, pulse_act, igr_trig;

    // Line history, edge detection, cell timing and bit decision.
    always_comb begin
        hist_d     = {hist_q[1:0], CTRL_i};
        neg_edge   = (hist_q[2:1] == 2'b10);
        pos_edge   = (hist_q[2:1] == 2'b01);
        any_edge   = neg_edge | pos_edge;
        wait_sat   = (wait_cnt_q == 8'hFF);
        wait_cnt_d = wait_cnt_q;
        if (any_edge) begin
            wait_cnt_d = 8'd0;
        end else if (!wait_sat) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
        low_cnt_d = pos_edge ? wait_cnt_q : low_cnt_q;
        // Short low phase followed by a longer high phase encodes a 1.
        bit_val   = (low_cnt_q < wait_cnt_q);
    end

    // Decode FSM: idle detection, command check, answer capture.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        frame_d     = frame_q;
        det_d       = det_q;
        frame_latch = 1'b0;
        if (wait_sat && !any_edge) begin
            // Line quiet too long: any transfer in progress is dead.
            state_d = StWait;
            if (state_q == StN64Rd) begin
                det_d = 1'b0;
            end
        end else if (neg_edge) begin
            case (state_q)
                StWait: begin
                    if (wait_sat) begin
                        state_d   = StN64Rd;
                        bit_cnt_d = 5'd0;
                        shreg_d   = 32'd0;
                    end
                end
                StN64Rd: begin
                    if (bit_cnt_q == 5'd8) begin
                        // This edge ends the console stop bit.
                        if (shreg_q[31:24] == PollCmdRev) begin
                            state_d   = StCtrlRd;
                            bit_cnt_d = 5'd0;
                            shreg_d   = 32'd0;
                        end else begin
                            state_d = StWait;
                        end
                    end else begin
                        shreg_d   = {bit_val, shreg_q[31:1]};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                StCtrlRd: begin
                    shreg_d = {bit_val, shreg_q[31:1]};
                    if (bit_cnt_q == 5'd31) begin
                        frame_d     = shreg_d;
                        frame_latch = 1'b1;
                        det_d       = 1'b1;
                        state_d     = StWait;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                default: state_d = StWait;
            endcase
        end
    end

    // Hand-off to the CPU domain; a fresh word beats a simultaneous ack.
    always_comb begin
        pend_d  = frame_latch;
        ack_chg = tack_sync_q[1] ^ tack_prev_q;
        data_d  = data_q;
        new_d   = new_q;
        if (ack_chg) begin
            new_d = 1'b0;
        end
        if (pend_q) begin
            data_d = frame_q;
            new_d  = 1'b1;
        end
    end

    // In-game reset: one pulse per held combo, re-armed by a non-combo frame.
    always_comb begin
        pulse_act = (rst_cnt_q != '0);
        igr_trig  = use_igr_sync_q[1] && (frame_q[15:0] == IGR_COMBO) && armed_q && !pulse_act;
        rst_cnt_d = rst_cnt_q;
        armed_d   = armed_q;
        if (igr_trig) begin
            rst_cnt_d = '1;
            armed_d   = 1'b0;
        end else if (pulse_act) begin
            rst_cnt_d = rst_cnt_q - 1'b1;
        end
        if (frame_latch && (frame_d[15:0] != IGR_COMBO)) begin
            armed_d = 1'b1;
        end
    end

    // State registers, including the foreign-domain synchronizers.
    always_ff @(posedge CTRL_CLK or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            use_igr_sync_q <= 2'b00;
            tack_sync_q    <= 2'b00;
            tack_prev_q    <= 1'b0;
            hist_q         <= 3'b111;
            wait_cnt_q     <= 8'd0;
            low_cnt_q      <= 8'd0;
            state_q        <= StWait;
            bit_cnt_q      <= 5'd0;
            shreg_q        <= 32'd0;
            frame_q        <= 32'd0;
            pend_q         <= 1'b0;
            det_q          <= 1'b0;
            data_q         <= 32'd0;
            new_q          <= 1'b0;
            armed_q        <= 1'b1;
            rst_cnt_q      <= '0;
        end else begin
            use_igr_sync_q <= {use_igr_sync_q[0], bus.use_igr_i};
            tack_sync_q    <= {tack_sync_q[0], bus.ctrl_data_tack_i};
            tack_prev_q    <= tack_sync_q[1];
            hist_q         <= hist_d;
            wait_cnt_q     <= wait_cnt_d;
            low_cnt_q      <= low_cnt_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            frame_q        <= frame_d;
            pend_q         <= pend_d;
            det_q          <= det_d;
            data_q         <= data_d;
            new_q          <= new_d;
            armed_q        <= armed_d;
            rst_cnt_q      <= rst_cnt_d;
        end
    end

    assign bus.ctrl_data_o     = data_q;
    assign bus.new_ctrl_data_o = new_q;
    assign bus.ctrl_detected_o = det_q;
    assign N64_nRST_io         = pulse_act ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_n64adv2_ctrl_sniffer.sv
// Directed-plus-random bench for the controller sniffer. Frames are built
// from bit cells on the line; expectations come from the protocol rules
// (accept only a 0x01 poll after a long idle, one IGR pulse per held combo).
`timescale 1ns/1ps
module tb_n64adv2_ctrl_sniffer;

    localparam int unsigned RstCntW  = 8;
    localparam int          PulseLen = (1 << RstCntW) - 1;
    localparam logic [15:0] Combo    = 16'h0C0C;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic ctrl_line = 1'b1;
    wire  n64_nrst;
    pullup (n64_nrst);

    n64adv2_ctrl_sniffer_if bus ();

    n64adv2_ctrl_sniffer #(
        .IGR_COMBO(Combo),
        .RST_CNT_W(RstCntW)
    ) dut (
        .CTRL_CLK   (clk),
        .CTRL_nRST  (rst_n),
        .CTRL_i     (ctrl_line),
        .bus        (bus),
        .N64_nRST_io(n64_nrst)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state of the sniffer as seen from outside.
    logic [31:0] m_data  = 32'd0;
    logic        m_new   = 1'b0;
    logic        m_det   = 1'b0;
    logic        m_armed = 1'b1;
    logic        m_use   = 1'b0;
    int          carry_hi = 0;

    // Reset-line activity, sampled on the falling clock edge.
    int   low_cycles = 0;
    int   pulses     = 0;
    logic line_prev  = 1'b1;
    always @(negedge clk) begin
        if (n64_nrst === 1'b0) begin
            low_cycles <= low_cycles + 1;
            if (line_prev) pulses <= pulses + 1;
        end
        line_prev <= (n64_nrst !== 1'b0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        ctrl_line = lvl;
        if (lvl) carry_hi += n;
        else carry_hi = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        hold(1'b0, b ? 4 : 12);
        hold(1'b1, b ? 12 : 4);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_data"}, bus.ctrl_data_o, m_data);
        check({tag, "_new"}, 32'(bus.new_ctrl_data_o), 32'(m_new));
        check({tag, "_det"}, 32'(bus.ctrl_detected_o), 32'(m_det));
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] word,
                             input int idle, input bit igr_chk);
        int   lo0;
        int   pu0;
        int   quiet;
        logic acc;
        logic exp_pulse;
        lo0 = low_cycles;
        pu0 = pulses;
        hold(1'b1, idle);
        quiet = carry_hi;
        for (int i = 7; i >= 0; i--) send_bit(cmd[i]);
        hold(1'b0, 4);
        hold(1'b1, 8);
        for (int i = 0; i < 32; i++) send_bit(word[i]);
        hold(1'b0, 4);
        hold(1'b1, 12);
        acc       = (cmd == 8'h01) && (quiet >= 260);
        exp_pulse = 1'b0;
        if (acc) begin
            m_data = word;
            m_new  = 1'b1;
            m_det  = 1'b1;
            if (word[15:0] != Combo) begin
                m_armed = 1'b1;
            end else if (m_use && m_armed) begin
                exp_pulse = 1'b1;
                m_armed   = 1'b0;
            end
        end
        check_outputs(tag);
        if (igr_chk) begin
            hold(1'b1, PulseLen + 40);
            check({tag, "_pulses"}, 32'(pulses - pu0), 32'(exp_pulse));
            check({tag, "_lowcyc"}, 32'(low_cycles - lo0), exp_pulse ? 32'(PulseLen) : 32'd0);
        end
    endtask

    task automatic ack(input string tag);
        bus.ctrl_data_tack_i = ~bus.ctrl_data_tack_i;
        hold(1'b1, 4);
        m_new = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  c;
        int          idle;
        bus.use_igr_i        = 1'b0;
        bus.ctrl_data_tack_i = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check("reset_line", 32'(n64_nrst), 32'd1);
        rst_n    = 1'b1;
        carry_hi = 0;

        // Plan frame, then ack, then a rejected command and a short idle.
        run_frame("plan", 8'h01, 32'h7F80_0001, 300, 1'b0);
        ack("ack");
        run_frame("badcmd", 8'hFF, $urandom, 300, 1'b0);
        run_frame("good2", 8'h01, 32'h1234_5678, 300, 1'b0);
        run_frame("shortidle", 8'h01, 32'hDEAD_BEEF, 100, 1'b0);

        // Line stuck low in the middle of a command.
        hold(1'b1, 300);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        hold(1'b0, 300);
        m_det = 1'b0;
        check_outputs("stucklow");
        run_frame("good3", 8'h01, 32'h0F0F_5A5A, 300, 1'b0);
        // Line stuck high in the middle of a command.
        hold(1'b1, 300);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        hold(1'b1, 300);
        m_det = 1'b0;
        check_outputs("stuckhigh");

        // Random frames: mostly valid polls, some bad commands or short idles.
        for (int k = 0; k < 8; k++) begin
            w    = $urandom;
            c    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(2, 255)) : 8'h01;
            idle = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 200) : $urandom_range(280, 400);
            run_frame("rand", c, w, idle, 1'b0);
            if ($urandom_range(0, 1) == 1) ack("rand_ack");
        end

        // IGR sequence.
        run_frame("igr_clear", 8'h01, {16'($urandom), 16'h0000}, 300, 1'b1);
        bus.use_igr_i = 1'b1;
        m_use         = 1'b1;
        run_frame("igr_combo", 8'h01, {16'($urandom), Combo}, 300, 1'b1);
        run_frame("igr_repeat", 8'h01, {16'($urandom), Combo}, 300, 1'b1);
        run_frame("igr_rearm", 8'h01, 32'h0000_0000, 300, 1'b1);
        run_frame("igr_again", 8'h01, {16'($urandom), Combo}, 300, 1'b1);
        run_frame("igr_rearm2", 8'h01, 32'h0000_0000, 300, 1'b1);
        bus.use_igr_i = 1'b0;
        m_use         = 1'b0;
        hold(1'b1, 8);
        run_frame("igr_off", 8'h01, {16'($urandom), Combo}, 300, 1'b1);

        // Enabling IGR with the combo frame still armed starts a pulse.
        bus.use_igr_i = 1'b1;
        hold(1'b1, 10);
        check("igr_enable_low", 32'(n64_nrst), 32'd0);
        rst_n = 1'b0;
        #1;
        check("igr_rst_release", 32'(n64_nrst), 32'd1);
        m_data = 32'd0;
        m_new  = 1'b0;
        m_det  = 1'b0;
        check_outputs("midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
